// File: rtl/v_upd_issue.sv
// Update-bus issue stage: host command FIFO feeding a registered, non-backpressured update bus.
// Define V_UPD_ISSUE_HAZARD_EN to space same-product issues by at least HAZARD_N idle cycles.
package v_pkg;
  typedef logic [7:0]  id_t;
  typedef logic [1:0]  cmd_t;
  typedef logic [15:0] key_t;
  typedef logic [7:0]  size_t;
endpackage

module v_upd_issue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned HAZARD_N = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cmd_vld,
  output logic          o_cmd_rdy,
  input  v_pkg::id_t    i_cmd_prod_id,
  input  v_pkg::cmd_t   i_cmd_cmd,
  input  v_pkg::key_t   i_cmd_key,
  input  v_pkg::size_t  i_cmd_size,
  input  logic          i_upd_hold,
  output logic          o_upd_vld_r,
  output v_pkg::id_t    o_upd_prod_id_r,
  output v_pkg::cmd_t   o_upd_cmd_r,
  output v_pkg::key_t   o_upd_key_r,
  output v_pkg::size_t  o_upd_size_r,
  output logic          o_empty_r,
  output logic [31:0]   o_issue_cnt_r,
  output logic [15:0]   o_stall_cnt_r
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    v_pkg::id_t   id;
    v_pkg::cmd_t  cmd;
    v_pkg::key_t  key;
    v_pkg::size_t size;
  } ent_t;

  ent_t           mem [DEPTH];
  ent_t           head;
  logic [AW-1:0]  wptr_r, rptr_r;
  logic [AW:0]    cnt_r, cnt_nxt;
  logic           full, empty, push, issue, hazard;

  assign full      = (cnt_r == (AW+1)'(DEPTH));
  assign empty     = (cnt_r == '0);
  assign o_cmd_rdy = ~full;
  assign push      = i_cmd_vld & ~full;
  assign head      = mem[rptr_r];
  assign issue     = ~empty & ~i_upd_hold & ~hazard;

  always_comb begin
    cnt_nxt = cnt_r;
    if (push && !issue)      cnt_nxt = cnt_r + 1'b1;
    else if (!push && issue) cnt_nxt = cnt_r - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_r] <= '{id: i_cmd_prod_id, cmd: i_cmd_cmd, key: i_cmd_key, size: i_cmd_size};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r          <= '0;
      rptr_r          <= '0;
      cnt_r           <= '0;
      o_upd_vld_r     <= 1'b0;
      o_upd_prod_id_r <= '0;
      o_upd_cmd_r     <= '0;
      o_upd_key_r     <= '0;
      o_upd_size_r    <= '0;
      o_empty_r       <= 1'b1;
      o_issue_cnt_r   <= '0;
    end else begin
      cnt_r       <= cnt_nxt;
      o_upd_vld_r <= issue;
      // Empty only when nothing is buffered and nothing is about to appear on the bus.
      o_empty_r   <= (cnt_nxt == '0) && !issue;
      if (push) wptr_r <= wptr_r + 1'b1;
      if (issue) begin
        rptr_r          <= rptr_r + 1'b1;
        o_upd_prod_id_r <= head.id;
        o_upd_cmd_r     <= head.cmd;
        o_upd_key_r     <= head.key;
        o_upd_size_r    <= head.size;
        o_issue_cnt_r   <= o_issue_cnt_r + 1'b1;
      end
    end
  end

`ifdef V_UPD_ISSUE_HAZARD_EN
  logic [HAZARD_N-1:0] hist_vld_r;
  v_pkg::id_t          hist_id_r [HAZARD_N];

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < HAZARD_N; i++)
      if (hist_vld_r[i] && (hist_id_r[i] == head.id)) hazard = 1'b1;
  end

  // Slot 0 receives this cycle's issue (or a bubble); older slots age toward HAZARD_N-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_vld_r <= '0;
      for (int unsigned i = 0; i < HAZARD_N; i++) hist_id_r[i] <= '0;
    end else begin
      hist_vld_r[0] <= issue;
      hist_id_r[0]  <= head.id;
      for (int unsigned i = 1; i < HAZARD_N; i++) begin
        hist_vld_r[i] <= hist_vld_r[i-1];
        hist_id_r[i]  <= hist_id_r[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      o_stall_cnt_r <= '0;
    else if (!empty && !i_upd_hold && hazard && (o_stall_cnt_r != '1))
      o_stall_cnt_r <= o_stall_cnt_r + 1'b1;
  end
`else
  assign hazard        = 1'b0;
  assign o_stall_cnt_r = '0;
`endif

endmodule

// File: tb/tb_v_upd_issue.sv
// Directed bench for v_upd_issue: scoreboard of pushed commands checked against the update bus.
module tb_v_upd_issue;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_cmd_vld = 1'b0;
  logic          o_cmd_rdy;
  v_pkg::id_t    i_cmd_prod_id = '0;
  v_pkg::cmd_t   i_cmd_cmd = '0;
  v_pkg::key_t   i_cmd_key = '0;
  v_pkg::size_t  i_cmd_size = '0;
  logic          i_upd_hold = 1'b0;
  logic          o_upd_vld_r;
  v_pkg::id_t    o_upd_prod_id_r;
  v_pkg::cmd_t   o_upd_cmd_r;
  v_pkg::key_t   o_upd_key_r;
  v_pkg::size_t  o_upd_size_r;
  logic          o_empty_r;
  logic [31:0]   o_issue_cnt_r;
  logic [15:0]   o_stall_cnt_r;

  v_upd_issue #(.DEPTH(4), .HAZARD_N(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy),
    .i_cmd_prod_id(i_cmd_prod_id), .i_cmd_cmd(i_cmd_cmd),
    .i_cmd_key(i_cmd_key), .i_cmd_size(i_cmd_size),
    .i_upd_hold(i_upd_hold), .o_upd_vld_r(o_upd_vld_r),
    .o_upd_prod_id_r(o_upd_prod_id_r), .o_upd_cmd_r(o_upd_cmd_r),
    .o_upd_key_r(o_upd_key_r), .o_upd_size_r(o_upd_size_r),
    .o_empty_r(o_empty_r), .o_issue_cnt_r(o_issue_cnt_r),
    .o_stall_cnt_r(o_stall_cnt_r)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [33:0] sb [$];
  int          log_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge; a command counts as accepted if ready is high now.
  task automatic drive(input bit v, input int id, input int cmd, input int key, input int size,
                       output bit acc);
    i_cmd_vld     = v;
    i_cmd_prod_id = v_pkg::id_t'(id);
    i_cmd_cmd     = v_pkg::cmd_t'(cmd);
    i_cmd_key     = v_pkg::key_t'(key);
    i_cmd_size    = v_pkg::size_t'(size);
    acc = v && o_cmd_rdy;
    if (acc) sb.push_back({i_cmd_prod_id, i_cmd_cmd, i_cmd_key, i_cmd_size});
  endtask

  always @(negedge clk) begin
    if (rst_n && o_upd_vld_r) begin
      log_q.push_back(cyc);
      if (sb.size() == 0)
        check("unexpected_issue", 64'(o_upd_vld_r), 64'd0);
      else
        check("issue_fields", 64'({o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r}),
              64'(sb.pop_front()));
    end
  end

  initial begin
    bit acc;
    int n_acc;
    int stall0;

    repeat (2) @(negedge clk);
    check("rst_rdy", 64'(o_cmd_rdy), 64'd1);
    check("rst_vld", 64'(o_upd_vld_r), 64'd0);
    check("rst_data", 64'({o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r}), 64'd0);
    check("rst_empty", 64'(o_empty_r), 64'd1);
    check("rst_issue_cnt", 64'(o_issue_cnt_r), 64'd0);
    check("rst_stall_cnt", 64'(o_stall_cnt_r), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single command: accepted at the next edge, visible two negedges later only.
    drive(1, 3, 1, 10, 5, acc);
    check("single_acc", 64'(acc), 64'd1);
    @(negedge clk); drive(0, 0, 0, 0, 0, acc);
    check("lat_t1_vld", 64'(o_upd_vld_r), 64'd0);
    @(negedge clk);
    check("lat_t2_vld", 64'(o_upd_vld_r), 64'd1);
    @(negedge clk);
    check("lat_t3_vld", 64'(o_upd_vld_r), 64'd0);
    check("single_issue_cnt", 64'(o_issue_cnt_r), 64'd1);

    // Fill under hold, then drain.
    i_upd_hold = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, 20 + i, i, 100 + i, i + 1, acc);
      if (acc) n_acc++;
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, acc);
    check("fill_accepted", 64'(n_acc), 64'd4);
    check("fill_rdy_low", 64'(o_cmd_rdy), 64'd0);
    check("fill_not_empty", 64'(o_empty_r), 64'd0);
    check("fill_no_issue", 64'(o_upd_vld_r), 64'd0);
    i_upd_hold = 1'b0;
    log_q.delete();
    @(negedge clk);
    check("rdy_after_pop", 64'(o_cmd_rdy), 64'd1);
    repeat (5) @(negedge clk);
    check("drain_count", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) check("drain_back_to_back", 64'(log_q[3] - log_q[0]), 64'd3);
    check("drain_empty", 64'(o_empty_r), 64'd1);

    // Same-ID spacing.
    stall0 = int'(o_stall_cnt_r);
    log_q.delete();
    @(negedge clk); drive(1, 7, 0, 70, 1, acc);
    @(negedge clk); drive(1, 7, 1, 71, 2, acc);
    @(negedge clk); drive(1, 2, 2, 72, 3, acc);
    @(negedge clk); drive(0, 0, 0, 0, 0, acc);
    repeat (12) @(negedge clk);
    check("sameid_count", 64'(log_q.size()), 64'd3);
`ifdef V_UPD_ISSUE_HAZARD_EN
    if (log_q.size() == 3) begin
      check("sameid_gap1", 64'(log_q[1] - log_q[0]), 64'd5);
      check("sameid_gap2", 64'(log_q[2] - log_q[1]), 64'd1);
    end
    check("sameid_stall", 64'(int'(o_stall_cnt_r) - stall0), 64'd4);
`else
    if (log_q.size() == 3) begin
      check("sameid_gap1", 64'(log_q[1] - log_q[0]), 64'd1);
      check("sameid_gap2", 64'(log_q[2] - log_q[1]), 64'd1);
    end
    check("sameid_stall", 64'(o_stall_cnt_r), 64'd0);
`endif

    // Hold for three cycles during a stream of four.
    log_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      i_upd_hold = (i >= 2 && i < 5);
      if (i < 4) drive(1, 40 + i, i, 400 + i, 9, acc);
      else       drive(0, 0, 0, 0, 0, acc);
    end
    repeat (4) @(negedge clk);
    check("hold_count", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      check("hold_gap", 64'(log_q[1] - log_q[0]), 64'd4);
      check("hold_resume", 64'(log_q[3] - log_q[1]), 64'd2);
    end
    check("issue_cnt_total", 64'(o_issue_cnt_r), 64'd12);

    // Asynchronous reset with three commands buffered.
    i_upd_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 50 + i, 3, 500 + i, 4, acc);
    end
    @(negedge clk); drive(0, 0, 0, 0, 0, acc);
    check("prereset_not_empty", 64'(o_empty_r), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld", 64'(o_upd_vld_r), 64'd0);
    check("arst_data", 64'({o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r}), 64'd0);
    check("arst_rdy", 64'(o_cmd_rdy), 64'd1);
    check("arst_empty", 64'(o_empty_r), 64'd1);
    check("arst_issue_cnt", 64'(o_issue_cnt_r), 64'd0);
    check("arst_stall_cnt", 64'(o_stall_cnt_r), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    i_upd_hold = 1'b0;
    log_q.delete();
    repeat (10) @(negedge clk);
    check("post_reset_no_issue", 64'(log_q.size()), 64'd0);
    check("post_reset_empty", 64'(o_empty_r), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
